lzs_bit_feeder: RTL and testbench

- Synthesizable MSB-first bit-window feeder for the LZS decoder front end; the RTL replacement for the bench stimulus feeder.
- Accepts WORD_W-bit words from an upstream FIFO into a left-aligned shift buffer and presents the top WIN_W bits to the decoder.
- The decoder consumes 0..MAX_TAKE bits per acknowledged cycle.
- Adds end-of-stream drain, optional byte alignment and sticky underrun detection.

---
 rtl/lzs_pkg.sv | 20 ++
 rtl/lzs_bit_shifter.sv | 23 ++
 rtl/lzs_bit_feeder.sv | 121 ++++++++++++
 tb/tb_lzs_bit_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lzs_pkg.sv
// Shared types and helpers for the LZS bit feeder and related stream logic.
// Used by both the feeder and the encoder-side packer.
package lzs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lzs_state_e;

    localparam int TAKE_W_DEF = 4;
    localparam int MAX_TAKE   = (1 << TAKE_W_DEF) - 1;

    // Returns the bit count needed to reach the next byte boundary.
    function automatic logic [2:0] align_pad(input logic [2:0] consumed);
        return 3'd0 - consumed;
    endfunction

endpackage

// File: rtl/lzs_bit_shifter.sv
// Combinational left shift of a bit buffer with an OR-insert of one word at a
// variable offset from the MSB. Shared by the feeder and the encoder packer.
module lzs_bit_shifter #(
    parameter int BUF_W  = 64,
    parameter int WORD_W = 16,
    parameter int SH_W   = $clog2(BUF_W + 1)
) (
    input  logic [BUF_W-1:0]  data_i,
    input  logic [SH_W-1:0]   shamt_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic              ins_en_i,
    input  logic [SH_W-1:0]   ins_off_i,
    output logic [BUF_W-1:0]  data_o
);

    logic [BUF_W-1:0] word_ext;
    logic [BUF_W-1:0] word_pos;

    assign word_ext = {word_i, {(BUF_W-WORD_W){1'b0}}};
    assign word_pos = ins_en_i ? (word_ext >> ins_off_i) : '0;
    assign data_o   = (data_i << shamt_i) | word_pos;

endmodule

// File: rtl/lzs_bit_feeder.sv
// MSB-first bit-window feeder for the LZS decoder: packs upstream words into a
// left-aligned shift buffer and presents the top WIN_W bits to the decoder.
//
// state | meaning
// IDLE  | no word seen since reset
// RUN   | streaming, window valid once WIN_W bits are buffered
// DRAIN | last word accepted, window valid while any bit remains
// DONE  | stream fully consumed, held until rst
module lzs_bit_feeder
    import lzs_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int WIN_W  = 13,
    parameter int BUF_W  = 64,
    parameter int TAKE_W = TAKE_W_DEF,
    parameter int CNT_W  = $clog2(BUF_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              stream_valid,
    output logic [WIN_W-1:0]  stream_data,
    output logic              stream_empty,
    input  logic              stream_ack,
    input  logic [TAKE_W-1:0] stream_width,
    input  logic              align_req,
    output logic              underrun_err
);

    localparam int TAKE_MAX = ((1 << TAKE_W) - 1 > MAX_TAKE) ? (1 << TAKE_W) - 1 : MAX_TAKE;
    localparam int SUM_W    = $clog2(BUF_W + TAKE_MAX + 8);

    lzs_state_e         state_q, state_d;
    logic [BUF_W-1:0]   shbuf_q, shbuf_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [2:0]         consumed_q, consumed_d;
    logic               err_q, err_d;

    logic [SUM_W-1:0]   take_c;
    logic [SUM_W-1:0]   pad_c;
    logic [SUM_W-1:0]   total_c;
    logic               underrun_c;
    logic [CNT_W-1:0]   left_c;
    logic [CNT_W-1:0]   shamt_c;
    logic               accept_c;
    logic [BUF_W-1:0]   shifted_c;

    always_comb begin
        stream_valid = 1'b0;
        case (state_q)
            RUN:     stream_valid = (left_q >= CNT_W'(WIN_W));
            DRAIN:   stream_valid = (left_q != '0);
            default: stream_valid = 1'b0;
        endcase
    end

    // Alignment pad is computed on the consumed count after this cycle's take.
    always_comb begin
        take_c     = (stream_ack && stream_valid) ? SUM_W'(stream_width) : '0;
        pad_c      = (align_req && stream_valid) ? SUM_W'(align_pad(consumed_q + take_c[2:0])) : '0;
        total_c    = take_c + pad_c;
        underrun_c = stream_valid && (int'(total_c) > int'(left_q));
        left_c     = underrun_c ? '0 : left_q - CNT_W'(total_c);
        shamt_c    = underrun_c ? '0 : CNT_W'(total_c);
        word_ready = !rst && !underrun_c && ((state_q == IDLE) || (state_q == RUN))
                     && (int'(left_c) + WORD_W <= BUF_W);
        accept_c   = word_valid && word_ready;
    end

    lzs_bit_shifter #(
        .BUF_W  (BUF_W),
        .WORD_W (WORD_W),
        .SH_W   (CNT_W)
    ) u_shifter (
        .data_i    (shbuf_q),
        .shamt_i   (shamt_c),
        .word_i    (word_data),
        .ins_en_i  (accept_c),
        .ins_off_i (left_c),
        .data_o    (shifted_c)
    );

    always_comb begin
        shbuf_d    = underrun_c ? '0 : shifted_c;
        left_d     = left_c + (accept_c ? CNT_W'(WORD_W) : '0);
        consumed_d = consumed_q + total_c[2:0];
        err_d      = err_q | underrun_c;
        state_d    = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = word_last ? DRAIN : RUN;
            RUN:     if (accept_c && word_last) state_d = DRAIN;
            DRAIN:   if (left_d == '0) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shbuf_q    <= '0;
            left_q     <= '0;
            consumed_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shbuf_q    <= shbuf_d;
            left_q     <= left_d;
            consumed_q <= consumed_d;
            err_q      <= err_d;
        end
    end

    assign stream_data  = shbuf_q[BUF_W-1 -: WIN_W];
    assign stream_empty = (state_q == DONE);
    assign underrun_err = err_q;

endmodule

// File: tb/tb_lzs_bit_feeder.sv
// Directed self-checking bench for lzs_bit_feeder, with a bit-queue reference
// model for the long continuous-ack stream.
module tb_lzs_bit_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        stream_valid;
    logic [12:0] stream_data;
    logic        stream_empty;
    logic        stream_ack;
    logic [3:0]  stream_width;
    logic        align_req;
    logic        underrun_err;

    int n_chk = 0;
    int n_err = 0;

    bit ref_bits [0:1023];

    lzs_bit_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .stream_valid (stream_valid),
        .stream_data  (stream_data),
        .stream_empty (stream_empty),
        .stream_ack   (stream_ack),
        .stream_width (stream_width),
        .align_req    (align_req),
        .underrun_err (underrun_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        word_valid   = 1'b0;
        word_data    = '0;
        word_last    = 1'b0;
        stream_ack   = 1'b0;
        stream_width = '0;
        align_req    = 1'b0;
        #1;
        chk("rst_ready", word_ready, 0);
        chk("rst_valid", stream_valid, 0);
        chk("rst_data",  stream_data, 0);
        chk("rst_empty", stream_empty, 0);
        chk("rst_err",   underrun_err, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [15:0] w, input logic last, input string tag);
        word_valid = 1'b1;
        word_data  = w;
        word_last  = last;
        #1;
        chk(tag, word_ready, 1);
        tick();
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic ack(input int w);
        stream_ack   = 1'b1;
        stream_width = 4'(w);
        tick();
        stream_ack   = 1'b0;
        stream_width = '0;
        #1;
    endtask

    function automatic logic [12:0] model_win(input int rc, input int nf);
        logic [12:0] r;
        r = '0;
        for (int i = 0; i < 13; i++)
            r[12-i] = (rc + i < nf) ? ref_bits[rc+i] : 1'b0;
        return r;
    endfunction

    initial begin
        int          nf, rc, k, lc;
        logic [15:0] w;
        logic        exp_valid;

        // Two words, window check.
        do_reset();
        push(16'hA5C3, 1'b0, "t1_ready0");
        push(16'h0F0F, 1'b0, "t1_ready1");
        #1;
        chk("t1_left",  dut.left_q, 32);
        chk("t1_valid", stream_valid, 1);
        chk("t1_data",  stream_data, 13'h14B8);

        // Continuous ack of 9 against the bit-queue model.
        do_reset();
        nf = 0; rc = 0; k = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            w            = 16'(16'h1357 * (k + 1));
            word_valid   = (k < 12);
            word_data    = w;
            stream_ack   = 1'b1;
            stream_width = 4'd9;
            #1;
            exp_valid = (nf - rc) >= 13;
            lc        = (nf - rc) - (exp_valid ? 9 : 0);
            chk("m_valid", stream_valid, exp_valid);
            chk("m_data",  stream_data, model_win(rc, nf));
            chk("m_ready", word_ready, (lc + 16 <= 64));
            if (word_valid && (lc + 16 <= 64)) begin
                for (int i = 0; i < 16; i++) ref_bits[nf+i] = w[15-i];
                nf += 16;
                k++;
            end
            if (exp_valid) rc += 9;
            tick();
        end
        word_valid = 1'b0;
        stream_ack = 1'b0;
        chk("m_words_all", k, 12);

        // Stall: fill to 64, then release with acks.
        do_reset();
        push(16'h1111, 1'b0, "st_r0");
        push(16'h2222, 1'b0, "st_r1");
        push(16'h3333, 1'b0, "st_r2");
        push(16'h4444, 1'b0, "st_r3");
        chk("st_left64", dut.left_q, 64);
        word_valid = 1'b1;
        word_data  = 16'h5555;
        #1;
        chk("st_full_ready", word_ready, 0);
        tick();
        word_valid = 1'b0;
        chk("st_left_hold", dut.left_q, 64);
        stream_ack   = 1'b1;
        stream_width = 4'd15;
        #1;
        chk("st_ack15_ready", word_ready, 0);
        tick();
        stream_width = 4'd1;
        #1;
        chk("st_ack1_ready", word_ready, 1);
        tick();
        stream_ack = 1'b0;
        #1;
        chk("st_left48", dut.left_q, 48);
        chk("st_data", stream_data, 13'h0444);

        // Single last word drained by 7, 7, 2.
        do_reset();
        push(16'hFFFF, 1'b1, "dr_ready");
        #1;
        chk("dr_valid0", stream_valid, 1);
        chk("dr_data0",  stream_data, 13'h1FFF);
        chk("dr_noready", word_ready, 0);
        ack(7);
        chk("dr_valid1", stream_valid, 1);
        chk("dr_data1",  stream_data, 13'h1FF0);
        ack(7);
        chk("dr_valid2", stream_valid, 1);
        chk("dr_data2",  stream_data, 13'h1800);
        ack(2);
        chk("dr_left0",  dut.left_q, 0);
        chk("dr_empty",  stream_empty, 1);
        chk("dr_valid3", stream_valid, 0);
        chk("dr_data3",  stream_data, 0);
        chk("dr_err",    underrun_err, 0);

        // Byte alignment after 11 consumed bits.
        do_reset();
        push(16'hABCD, 1'b0, "al_r0");
        push(16'h1234, 1'b0, "al_r1");
        ack(11);
        chk("al_data11", stream_data, 13'h0D12);
        chk("al_cons3",  dut.consumed_q, 3);
        align_req = 1'b1;
        ack(0);
        align_req = 1'b0;
        chk("al_left",  dut.left_q, 16);
        chk("al_cons0", dut.consumed_q, 0);
        chk("al_data",  stream_data, 13'h0246);

        // Underrun in DRAIN.
        do_reset();
        push(16'hFFFF, 1'b1, "ur_ready");
        ack(13);
        chk("ur_left3", dut.left_q, 3);
        chk("ur_valid", stream_valid, 1);
        ack(5);
        chk("ur_err",   underrun_err, 1);
        chk("ur_empty", stream_empty, 1);
        chk("ur_left0", dut.left_q, 0);
        tick();
        chk("ur_sticky", underrun_err, 1);

        // Asynchronous reset mid-RUN drops a presented word.
        do_reset();
        push(16'hA5C3, 1'b0, "ar_r0");
        push(16'h0F0F, 1'b0, "ar_r1");
        chk("ar_valid", stream_valid, 1);
        word_valid = 1'b1;
        word_data  = 16'hBEEF;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid0", stream_valid, 0);
        chk("ar_data0",  stream_data, 0);
        chk("ar_ready0", word_ready, 0);
        chk("ar_left0",  dut.left_q, 0);
        tick();
        tick();
        word_valid = 1'b0;
        rst        = 1'b0;
        #1;
        chk("ar_left_after", dut.left_q, 0);
        chk("ar_empty", stream_empty, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
